apb_mem_subsys: RTL and testbench
=================================

# apb_mem_subsys

Parametrised APB subsystem: a single APB master FSM driven by a simple transfer request port, an address decoder, and NUM_SLAVES register-file slaves with a configurable number of wait states. It extends the single-master/single-slave APB top with:
- generic address/data widths
- multiple slaves
- PREADY wait states
- PSLVERR on unmapped addresses
- back-to-back transfers without returning to IDLE

It sits between the local request logic and the peripheral register space.

## Interface
Parameters:
- ADDR_WIDTH, 8, request address width; must be ≥ log2(NUM_SLAVES*SLAVE_DEPTH).
- DATA_WIDTH, 8, data width of wdata/rdata and of every slave word.
- NUM_SLAVES, 2, number of slave register files (1..8).
- SLAVE_DEPTH, 64, words per slave; power of two.
- WAIT_STATES, 0, ACCESS cycles each slave holds PREADY low (0..15).

Ports:
- pclk  in  1  clock; all logic on rising edge.
- prstn  in  1  asynchronous, active-low reset.
- transfer  in  1  request; sampled in IDLE and at transfer completion.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  ADDR_WIDTH  byte-less word address; sampled with transfer.
- wdata  in  DATA_WIDTH  write data; sampled with transfer.
- rdata  out  DATA_WIDTH  last completed read data, registered.
- done  out  1  one-cycle pulse per completed transfer.
- err  out  1  valid with done; 1 = PSLVERR (unmapped address).
- busy  out  1  1 while state ≠ IDLE.
- psel  out  NUM_SLAVES  one-hot APB select (observation).
- penable  out  1  APB enable (observation).
- pwrite  out  1  APB direction (observation).
- preadyout  out  1  muxed PREADY of the selected slave (observation).

## Operation
- Address decode: slave index = addr / SLAVE_DEPTH, offset = addr % SLAVE_DEPTH. An index ≥ NUM_SLAVES is unmapped.
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE: if transfer=1, latch addr/write/wdata into request registers and go to SETUP.
  - SETUP: psel[index]=1 (all zero if unmapped), penable=0, pwrite=latched write. Always go to ACCESS.
  - ACCESS: psel held, penable=1. Stay while preadyout=0.
- On preadyout=1 in ACCESS:
  - Write: commit wdata to slave[index][offset].
  - Read: rdata ← slave[index][offset].
  - done pulses next cycle; err = unmapped.
  - If transfer=1 at that edge: latch the new request and go to SETUP (back-to-back). Otherwise go to IDLE.
- Unmapped address: no psel asserted. The master forces preadyout=1 in the first ACCESS cycle (no wait states) with PSLVERR. No memory is written, and rdata keeps its previous value.
- Slave wait counter:
  - Clears in SETUP and increments each ACCESS cycle.
  - PREADY=1 when counter == WAIT_STATES.
  - Counter width is 4 bits and saturates; no wrap.
- psel, pwrite and the request registers are stable from SETUP through the final ACCESS cycle.
- addr/wdata/write changes outside sampling edges have no effect.

## Timing
- Reset (prstn=0, asynchronous):
  - State → IDLE.
  - rdata, done, err, busy, psel, penable, pwrite, preadyout, wait counter, request registers = 0.
  - All slave words = 0.
- Reset mid-transfer aborts it. A write not yet committed at the PREADY edge is lost. done is not pulsed.
- Latency, with transfer sampled high at edge E0 in IDLE:
  - SETUP after E0, ACCESS after E1.
  - Completion edge is E2+WAIT_STATES; done/err/rdata valid after that edge for exactly one cycle (rdata holds afterwards).
  - Idle-to-done latency is 3+WAIT_STATES cycles. Unmapped transfers take 3 cycles regardless of WAIT_STATES.
- Back-to-back: the next SETUP follows completion immediately. Throughput is one transfer per 2+WAIT_STATES cycles.
- busy=1 from the cycle after E0 until the cycle after the final completion with transfer=0.
- Simultaneous events:
  - A read of the location written by the immediately preceding back-to-back transfer returns the new data.
  - transfer held high continuously produces consecutive transfers, each re-sampling addr/write/wdata at its completion edge.

## Test plan
- Reset, then write 0xAB to addr 0x5A and read 0x5A (WAIT_STATES=0, defaults). Required: write done at cycle 3; read done with rdata=0xAB and err=0; psel=2'b10 during both transfers.
- WAIT_STATES=3: write 0x11 to addr 0x05, then read it back. Required: penable high for 4 cycles per transfer; done 6 cycles after the sample; rdata=0x11.
- Hold transfer high across write 0x3C@0x10 → read 0x10 → write 0xC3@0x50 → read 0x50. Required: no IDLE between transfers; reads return 0x3C and 0xC3; 4 done pulses, each 2 cycles apart.
- Access addr 0x80 (unmapped with NUM_SLAVES=2, SLAVE_DEPTH=64), both write and read. Required: psel=0; err=1 with done; rdata unchanged; slave contents unchanged.
- Assert prstn=0 during ACCESS of a write 0x77@0x20 with WAIT_STATES=2, before PREADY. Required: all outputs 0 asynchronously; a subsequent read of 0x20 returns 0x00.
- DATA_WIDTH=16, ADDR_WIDTH=10, NUM_SLAVES=4, SLAVE_DEPTH=128: write 0xBEEF to 0x1FF, then read it. Required: psel=4'b1000; rdata=0xBEEF; err=0.

Source files
------------

// File: rtl/apb_mem_subsys.sv
// APB subsystem: one request-driven master FSM, address decoder and NUM_SLAVES
// register-file slaves that insert WAIT_STATES cycles before PREADY.
module apb_rf_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SLAVE_DEPTH = 64,
    parameter int WAIT_STATES = 0,
    parameter int OFF_W       = $clog2(SLAVE_DEPTH)
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [OFF_W-1:0]      paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready
);
    logic [SLAVE_DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic [3:0]                             r_cnt;
    logic                                   w_wr;

    assign pready = (r_cnt == 4'(WAIT_STATES));
    assign prdata = r_mem[paddr];
    assign w_wr   = psel & penable & pready & pwrite;

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_cnt <= '0;
            r_mem <= '0;
        end else begin
            if (psel && !penable)
                r_cnt <= '0;
            else if (psel && penable && r_cnt != 4'hF)
                r_cnt <= r_cnt + 4'd1;
            if (w_wr)
                r_mem[paddr] <= pwdata;
        end
    end
endmodule

module apb_mem_subsys #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SLAVES  = 2,
    parameter int SLAVE_DEPTH = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic                  preadyout
);
    localparam int OFF_W = $clog2(SLAVE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                r_state;
    logic [OFF_W-1:0]      r_off;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_unmapped;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic                  r_err;
    logic                  r_busy;

    logic [NUM_SLAVES-1:0]                 w_pready;
    logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] w_prdata;
    logic [NUM_SLAVES-1:0]                 w_dec;
    logic                                  w_sel_ready;
    logic [DATA_WIDTH-1:0]                 w_sel_rdata;
    logic                                  w_preadyout;
    logic                                  w_take;

    function automatic logic [NUM_SLAVES-1:0] f_decode(input logic [ADDR_WIDTH-1:0] a);
        logic [NUM_SLAVES-1:0] res;
        logic [ADDR_WIDTH-1:0] idx;
        idx = a >> OFF_W;
        res = '0;
        for (int s = 0; s < NUM_SLAVES; s++)
            if (idx == ADDR_WIDTH'(s)) res[s] = 1'b1;
        return res;
    endfunction

    assign w_dec = f_decode(addr);

    generate
        for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
            apb_rf_slave #(
                .DATA_WIDTH (DATA_WIDTH),
                .SLAVE_DEPTH(SLAVE_DEPTH),
                .WAIT_STATES(WAIT_STATES),
                .OFF_W      (OFF_W)
            ) u_slv (
                .pclk   (pclk),
                .prstn  (prstn),
                .psel   (r_psel[g]),
                .penable(r_penable),
                .pwrite (r_pwrite),
                .paddr  (r_off),
                .pwdata (r_wdata),
                .prdata (w_prdata[g]),
                .pready (w_pready[g])
            );
        end
    endgenerate

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (r_psel[s]) begin
                w_sel_ready = w_sel_ready | w_pready[s];
                w_sel_rdata = w_sel_rdata | w_prdata[s];
            end
        end
    end

    // Unmapped requests select nobody, so the master completes them itself.
    assign w_preadyout = r_penable & (r_unmapped | w_sel_ready);
    assign w_take      = transfer & ((r_state == S_IDLE) | ((r_state == S_ACCESS) & w_preadyout));

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_state    <= S_IDLE;
            r_off      <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_unmapped <= 1'b0;
            r_psel     <= '0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: ;
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_preadyout) begin
                        r_done    <= 1'b1;
                        r_err     <= r_unmapped;
                        r_penable <= 1'b0;
                        if (!r_write && !r_unmapped)
                            r_rdata <= w_sel_rdata;
                        if (!transfer) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_psel   <= '0;
                            r_pwrite <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // New request from IDLE or straight off a completion edge (back-to-back).
            if (w_take) begin
                r_off      <= addr[OFF_W-1:0];
                r_write    <= write;
                r_wdata    <= wdata;
                r_psel     <= w_dec;
                r_unmapped <= ~|w_dec;
                r_pwrite   <= write;
                r_state    <= S_SETUP;
                r_busy     <= 1'b1;
            end
        end
    end

    assign rdata     = r_rdata;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign preadyout = w_preadyout;
endmodule

// File: tb/tb_apb_mem_subsys.sv
// Scoreboard bench: instance A uses defaults (no wait states), instance B is
// 16-bit / 4 slaves / 3 wait states.
module tb_apb_mem_subsys;
    localparam int WS_A = 0;
    localparam int WS_B = 3;

    logic pclk = 1'b0;
    int   cyc  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       rstn_a, tr_a, wr_a;
    logic [7:0] ad_a, wd_a, rd_a;
    logic       done_a, err_a, busy_a, pen_a, pwr_a, prdy_a;
    logic [1:0] psel_a;

    logic        rstn_b, tr_b, wr_b;
    logic [9:0]  ad_b;
    logic [15:0] wd_b, rd_b;
    logic        done_b, err_b, busy_b, pen_b, pwr_b, prdy_b;
    logic [3:0]  psel_b;

    typedef struct {
        logic [15:0] rd;
        logic        err;
        logic [3:0]  psel;
        int          cyc;
        int          pen;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    apb_mem_subsys u_dut_a (
        .pclk(pclk), .prstn(rstn_a), .transfer(tr_a), .write(wr_a), .addr(ad_a), .wdata(wd_a),
        .rdata(rd_a), .done(done_a), .err(err_a), .busy(busy_a), .psel(psel_a),
        .penable(pen_a), .pwrite(pwr_a), .preadyout(prdy_a)
    );

    apb_mem_subsys #(
        .ADDR_WIDTH(10), .DATA_WIDTH(16), .NUM_SLAVES(4), .SLAVE_DEPTH(128), .WAIT_STATES(WS_B)
    ) u_dut_b (
        .pclk(pclk), .prstn(rstn_b), .transfer(tr_b), .write(wr_b), .addr(ad_b), .wdata(wd_b),
        .rdata(rd_b), .done(done_b), .err(err_b), .busy(busy_b), .psel(psel_b),
        .penable(pen_b), .pwrite(pwr_b), .preadyout(prdy_b)
    );

    initial forever #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive a request and return just after the edge that samples it.
    task automatic issue(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] erd, input logic eerr, input logic [3:0] epsel);
        exp_t e;
        int   n;
        int   k;
        logic s;
        @(negedge pclk);
        if (d == 0) begin tr_a = 1'b1; wr_a = w; ad_a = a[7:0]; wd_a = wd[7:0]; end
        else        begin tr_b = 1'b1; wr_b = w; ad_b = a[9:0]; wd_b = wd;      end
        n = 0;
        forever begin
            s = (d == 0) ? (!busy_a || (pen_a && prdy_a)) : (!busy_b || (pen_b && prdy_b));
            k = cyc;
            @(posedge pclk);
            if (s) break;
            n++;
            if (n > 50) begin
                chk("issue_timeout", 32'(n), 32'(50));
                break;
            end
            @(negedge pclk);
        end
        e.rd   = erd;
        e.err  = eerr;
        e.psel = epsel;
        e.cyc  = k + 3 + (eerr ? 0 : ((d == 0) ? WS_A : WS_B));
        e.pen  = eerr ? 1 : ((d == 0) ? WS_A : WS_B) + 1;
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    task automatic idle(input int d);
        @(negedge pclk);
        if (d == 0) tr_a = 1'b0; else tr_b = 1'b0;
    endtask

    int         pc_a = 0;
    logic [3:0] ps_a = '0;
    always @(negedge pclk) begin : mon_a
        exp_t e;
        if (!rstn_a) pc_a = 0;
        else begin
            if (pen_a) begin
                pc_a++;
                if (prdy_a) ps_a = {2'b00, psel_a};
            end
            if (done_a) begin
                chk("a_done_expected", 32'(q_a.size() > 0), 32'd1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk("a_rdata",   {16'd0, 8'd0, rd_a}, {16'd0, e.rd});
                    chk("a_err",     {31'd0, err_a},      {31'd0, e.err});
                    chk("a_psel",    {28'd0, ps_a},       {28'd0, e.psel});
                    chk("a_latency", 32'(cyc),            32'(e.cyc));
                    chk("a_penable_cycles", 32'(pc_a),    32'(e.pen));
                end
                pc_a = 0;
            end
        end
    end

    int         pc_b = 0;
    logic [3:0] ps_b = '0;
    always @(negedge pclk) begin : mon_b
        exp_t e;
        if (!rstn_b) pc_b = 0;
        else begin
            if (pen_b) begin
                pc_b++;
                if (prdy_b) ps_b = psel_b;
            end
            if (done_b) begin
                chk("b_done_expected", 32'(q_b.size() > 0), 32'd1);
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    chk("b_rdata",   {16'd0, rd_b},  {16'd0, e.rd});
                    chk("b_err",     {31'd0, err_b}, {31'd0, e.err});
                    chk("b_psel",    {28'd0, ps_b},  {28'd0, e.psel});
                    chk("b_latency", 32'(cyc),       32'(e.cyc));
                    chk("b_penable_cycles", 32'(pc_b), 32'(e.pen));
                end
                pc_b = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_a = 1'b0; tr_a = 1'b0; wr_a = 1'b0; ad_a = '0; wd_a = '0;
        rstn_b = 1'b0; tr_b = 1'b0; wr_b = 1'b0; ad_b = '0; wd_b = '0;
        repeat (2) @(negedge pclk);
        chk("a_reset_outputs", {16'd0, rd_a, done_a, err_a, busy_a, psel_a, pen_a, pwr_a, prdy_a}, 32'd0);
        chk("b_reset_outputs", {6'd0, rd_b, done_b, err_b, busy_b, psel_b, pen_b, pwr_b, prdy_b}, 32'd0);
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        // A: write then read back
        issue(0, 1'b1, 16'h05A, 16'hAB, 16'h00, 1'b0, 4'b0010); idle(0);
        issue(0, 1'b0, 16'h05A, 16'h00, 16'hAB, 1'b0, 4'b0010); idle(0);
        repeat (3) @(negedge pclk);
        // A: four back-to-back transfers, transfer held high
        issue(0, 1'b1, 16'h010, 16'h3C, 16'hAB, 1'b0, 4'b0001);
        issue(0, 1'b0, 16'h010, 16'h00, 16'h3C, 1'b0, 4'b0001);
        issue(0, 1'b1, 16'h050, 16'hC3, 16'h3C, 1'b0, 4'b0010);
        issue(0, 1'b0, 16'h050, 16'h00, 16'hC3, 1'b0, 4'b0010);
        idle(0);
        repeat (3) @(negedge pclk);
        // A: unmapped write/read, then confirm no slave word was touched
        issue(0, 1'b1, 16'h080, 16'h99, 16'hC3, 1'b1, 4'b0000); idle(0);
        issue(0, 1'b0, 16'h080, 16'h00, 16'hC3, 1'b1, 4'b0000); idle(0);
        issue(0, 1'b0, 16'h000, 16'h00, 16'h00, 1'b0, 4'b0001); idle(0);
        issue(0, 1'b0, 16'h040, 16'h00, 16'h00, 1'b0, 4'b0010); idle(0);

        // B: wait states, wide data, top slave, unmapped
        issue(1, 1'b1, 16'h005, 16'h0011, 16'h0000, 1'b0, 4'b0001); idle(1);
        issue(1, 1'b0, 16'h005, 16'h0000, 16'h0011, 1'b0, 4'b0001); idle(1);
        issue(1, 1'b1, 16'h1FF, 16'hBEEF, 16'h0011, 1'b0, 4'b1000); idle(1);
        issue(1, 1'b0, 16'h1FF, 16'h0000, 16'hBEEF, 1'b0, 4'b1000); idle(1);
        issue(1, 1'b1, 16'h200, 16'h5555, 16'hBEEF, 1'b0 | 1'b1, 4'b0000); idle(1);
        repeat (4) @(negedge pclk);

        // B: reset during the first ACCESS cycle of a write, before PREADY
        issue(1, 1'b1, 16'h020, 16'h0077, 16'hBEEF, 1'b0, 4'b0001); idle(1);
        @(negedge pclk);
        chk("b_in_access_not_ready", {30'd0, pen_b, prdy_b}, 32'b10);
        #1 rstn_b = 1'b0;
        #1 chk("b_async_reset_outputs", {6'd0, rd_b, done_b, err_b, busy_b, psel_b, pen_b, pwr_b, prdy_b}, 32'd0);
        q_b.delete();
        @(negedge pclk);
        #1 rstn_b = 1'b1;
        issue(1, 1'b0, 16'h020, 16'h0000, 16'h0000, 1'b0, 4'b0001); idle(1);
        issue(1, 1'b0, 16'h1FF, 16'h0000, 16'h0000, 1'b0, 4'b1000); idle(1);

        for (int i = 0; i < 40; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge pclk);
        end
        chk("queues_drained", 32'(q_a.size() + q_b.size()), 32'd0);
        repeat (2) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
